// File: rtl/axi_read_streamer_if.sv
// AXI4 bus bundle shared by the read streamer and whatever slave it drives.
// The master modport owns the address/data requests; the slave modport owns the responses.
interface axi_interface #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 256
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_streamer.sv
// AXI4 read master: splits a (start address, beat count) command into INCR bursts that respect
// MAX_BURST and 4 KiB pages, and forwards the returned data as a valid/ready stream.
module axi_read_streamer #(
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 256,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned LEN_WIDTH       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_beats_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  done_o,
  output logic                  error_o,
  axi_interface.master          m_axi
);
  localparam int unsigned BeatBytes = DATA_WIDTH / 8;
  localparam int unsigned SizeLog   = $clog2(BeatBytes);
  localparam int unsigned OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW        = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(BeatBytes - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                state_q;
  logic                  cmd_ready_q, arvalid_q, done_q, error_q;
  logic [7:0]            arlen_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  ar_left_q, ar_left_d, r_left_q;
  logic [OW-1:0]         outst_q, outst_d;
  logic [8:0]            n_q, n_d;
  logic                  cmd_fire, ar_hs, r_hs, rlast_hs, issue_d;

  // Beats until the next limit: remaining count, MAX_BURST, or the end of the 4 KiB page.
  function automatic logic [8:0] burst_len(logic [11:0] off, logic [LEN_WIDTH-1:0] left);
    logic [12:0] to_bnd;
    logic [8:0]  n;
    to_bnd = (13'd4096 - {1'b0, off}) >> SizeLog;
    n      = 9'(MAX_BURST);
    if (CW'(to_bnd) < CW'(n)) n = 9'(to_bnd);
    if (CW'(left) < CW'(n))   n = 9'(left);
    return n;
  endfunction

  always_comb begin
    cmd_fire  = (state_q == StIdle) && cmd_valid_i && cmd_ready_q;
    ar_hs     = arvalid_q && m_axi.arready;
    r_hs      = (state_q == StRun) && m_axi.rvalid && out_ready_i;
    rlast_hs  = r_hs && m_axi.rlast;
    n_q       = {1'b0, arlen_q} + 9'd1;
    addr_d    = addr_q;
    ar_left_d = ar_left_q;
    if (cmd_fire) begin
      addr_d    = cmd_addr_i & AlignMask;
      ar_left_d = cmd_beats_i;
    end else if (ar_hs) begin
      addr_d    = addr_q + (ADDR_WIDTH'(n_q) << SizeLog);
      ar_left_d = ar_left_q - LEN_WIDTH'(n_q);
    end
    outst_d = outst_q;
    if (ar_hs && !rlast_hs)      outst_d = outst_q + OW'(1);
    else if (!ar_hs && rlast_hs) outst_d = outst_q - OW'(1);
    issue_d = (ar_left_d != '0) && (outst_d < OW'(MAX_OUTSTANDING));
    n_d     = burst_len(addr_d[11:0], ar_left_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      arlen_q     <= '0;
      addr_q      <= '0;
      ar_left_q   <= '0;
      r_left_q    <= '0;
      outst_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= addr_d;
            ar_left_q   <= ar_left_d;
            r_left_q    <= cmd_beats_i;
            outst_q     <= '0;
            error_q     <= 1'b0;
            if (cmd_beats_i == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StRun;
              arvalid_q <= 1'b1;
              arlen_q   <= 8'(n_d - 9'd1);
            end
          end
        end
        StRun: begin
          addr_q    <= addr_d;
          ar_left_q <= ar_left_d;
          outst_q   <= outst_d;
          // AR fields may only move once the current request has been taken.
          if (!arvalid_q || m_axi.arready) begin
            arvalid_q <= issue_d;
            if (issue_d) arlen_q <= 8'(n_d - 9'd1);
          end
          if (r_hs) begin
            r_left_q <= r_left_q - LEN_WIDTH'(1);
            if (m_axi.rresp != 2'b00) error_q <= 1'b1;
            if (r_left_q == LEN_WIDTH'(1)) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end
        end
        StFin: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign out_valid_o = (state_q == StRun) && m_axi.rvalid;
  assign out_data_o  = m_axi.rdata;
  assign out_last_o  = out_valid_o && (r_left_q == LEN_WIDTH'(1));

  assign m_axi.arid     = ID_WIDTH'(0);
  assign m_axi.araddr   = addr_q;
  assign m_axi.arlen    = arlen_q;
  assign m_axi.arsize   = 3'(SizeLog);
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'd0;
  assign m_axi.arprot   = 3'd0;
  assign m_axi.arqos    = 4'd0;
  assign m_axi.arregion = 4'd0;
  assign m_axi.arvalid  = arvalid_q;
  assign m_axi.rready   = (state_q == StRun) && out_ready_i;

  assign m_axi.awid     = ID_WIDTH'(0);
  assign m_axi.awaddr   = '0;
  assign m_axi.awlen    = 8'd0;
  assign m_axi.awsize   = 3'd0;
  assign m_axi.awburst  = 2'b00;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = 4'd0;
  assign m_axi.awprot   = 3'd0;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;
  assign m_axi.awvalid  = 1'b0;
  assign m_axi.wdata    = '0;
  assign m_axi.wstrb    = '0;
  assign m_axi.wlast    = 1'b0;
  assign m_axi.wvalid   = 1'b0;
  assign m_axi.bready   = 1'b1;
endmodule

// File: tb/tb_axi_read_streamer.sv
// Directed bench for axi_read_streamer with a queue-based AXI read slave whose data
// pattern is derived from the beat address.
module tb_axi_read_streamer;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 256;
  localparam int unsigned LW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_beats = '0;
  logic          out_ready = 1'b1;
  logic          cmd_ready, out_valid, out_last, done, error;
  logic [DW-1:0] out_data;

  logic          arready_en = 1'b1;
  logic          r_hold = 1'b0;
  logic [63:0]   err_addr = '1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  axi_interface #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_read_streamer #(
    .ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_BURST(16), .MAX_OUTSTANDING(4), .LEN_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last),
    .done_o(done), .error_o(error),
    .m_axi(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(logic [63:0] a);
    return {8{a[31:0]}};
  endfunction

  // ---------------- AXI read slave model ----------------
  logic        r_active;
  logic [63:0] r_addr;
  logic [7:0]  r_rem;
  logic [63:0] pend_a[$];
  logic [7:0]  pend_l[$];

  assign bus.arready = arready_en;
  assign bus.rvalid  = r_active;
  assign bus.rdata   = pat(r_addr);
  assign bus.rlast   = r_active && (r_rem == 8'd0);
  assign bus.rresp   = (r_active && r_addr == err_addr) ? 2'b10 : 2'b00;
  assign bus.rid     = '0;
  assign bus.awready = 1'b0;
  assign bus.wready  = 1'b0;
  assign bus.bvalid  = 1'b0;
  assign bus.bid     = '0;
  assign bus.bresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_a.delete();
      pend_l.delete();
      r_active <= 1'b0;
      r_addr   <= '0;
      r_rem    <= '0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        pend_a.push_back(bus.araddr);
        pend_l.push_back(bus.arlen);
      end
      if (r_active) begin
        if (bus.rvalid && bus.rready) begin
          if (r_rem == 8'd0) r_active <= 1'b0;
          else begin
            r_addr <= r_addr + 64'd32;
            r_rem  <= r_rem - 8'd1;
          end
        end
      end else if (!r_hold && pend_a.size() > 0) begin
        r_addr   <= pend_a.pop_front();
        r_rem    <= pend_l.pop_front();
        r_active <= 1'b1;
      end
    end
  end

  // ---------------- monitors (sampled mid-cycle) ----------------
  logic [DW-1:0] od_q[$];
  bit            ol_q[$];
  int            oc_q[$];
  logic [63:0]   ara_q[$];
  logic [7:0]    arl_q[$];
  logic [2:0]    ars_q[$];
  logic [1:0]    arb_q[$];
  int            done_n = 0;
  int            done_c = -1;
  int            err_rise = -1;
  bit            err_prev = 1'b0;
  int            cross_n = 0;
  int            rr_mis = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      od_q.push_back(out_data);
      ol_q.push_back(out_last);
      oc_q.push_back(cyc);
    end
    if (done) begin
      done_n = done_n + 1;
      done_c = cyc;
    end
    if (bus.arvalid && bus.arready) begin
      ara_q.push_back(bus.araddr);
      arl_q.push_back(bus.arlen);
      ars_q.push_back(bus.arsize);
      arb_q.push_back(bus.arburst);
      if ({52'd0, bus.araddr[11:0]} + (64'(bus.arlen) + 64'd1) * 64'd32 > 64'd4096)
        cross_n = cross_n + 1;
    end
    if (error && !err_prev) err_rise = cyc;
    err_prev = error;
    if (bus.rvalid && (bus.rready !== out_ready)) rr_mis = rr_mis + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input logic [63:0] a, input int n, output int acc);
    int k = 0;
    @(posedge clk); #1;
    while (cmd_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_timeout addr=%h got=%b want=1", a, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = LW'(n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int start, input int budget, input string name);
    int k = 0;
    while (done_n == start && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (done_n == start) begin
      failures++;
      $display("FAIL %s done_timeout got=none want=pulse within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++;
    if ({cmd_ready, bus.arvalid, bus.rready, out_valid, out_last, done, error} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {cmd_ready, bus.arvalid, bus.rready, out_valid, out_last, done, error});
    end
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin
      failures++;
      $display("FAIL tieoffs got=%b want=001", {bus.awvalid, bus.wvalid, bus.bready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_cmd_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_single();
    int a0 = ara_q.size();
    int b0 = od_q.size();
    int d0 = done_n;
    int acc;
    send_cmd(64'h1000, 4, acc);
    wait_done(d0, 200, "single");
    checks++;
    if (ara_q.size() - a0 != 1) begin
      failures++;
      $display("FAIL single_ar_count got=%0d want=1", ara_q.size() - a0);
    end
    checks++;
    if ({ara_q[a0], arl_q[a0], ars_q[a0], arb_q[a0]} !== {64'h1000, 8'd3, 3'd5, 2'd1}) begin
      failures++;
      $display("FAIL single_ar_fields got=%h/%0d/%0d/%0d want=1000/3/5/1",
               ara_q[a0], arl_q[a0], ars_q[a0], arb_q[a0]);
    end
    checks++;
    if (od_q.size() - b0 != 4) begin
      failures++;
      $display("FAIL single_beats got=%0d want=4", od_q.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od_q[b0+i] !== pat(64'h1000 + 64'(i) * 32) || ol_q[b0+i] !== (i == 3)) begin
        failures++;
        $display("FAIL single_beat%0d got=%h last=%b want=%h last=%b", i, od_q[b0+i],
                 ol_q[b0+i], pat(64'h1000 + 64'(i) * 32), (i == 3));
      end
    end
    checks++;
    if (done_n - d0 != 1 || done_c != oc_q[b0+3] + 1) begin
      failures++;
      $display("FAIL single_done got=%0d pulses at %0d want=1 pulse at %0d",
               done_n - d0, done_c, oc_q[b0+3] + 1);
    end
  endtask

  task automatic test_split();
    logic [63:0] ea[3] = '{64'h000, 64'h200, 64'h400};
    logic [7:0]  el[3] = '{8'd15, 8'd15, 8'd7};
    int a0 = ara_q.size();
    int b0 = od_q.size();
    int d0 = done_n;
    int acc;
    send_cmd(64'h0, 40, acc);
    wait_done(d0, 400, "split");
    checks++;
    if (ara_q.size() - a0 != 3) begin
      failures++;
      $display("FAIL split_ar_count got=%0d want=3", ara_q.size() - a0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ara_q[a0+i] !== ea[i] || arl_q[a0+i] !== el[i]) begin
        failures++;
        $display("FAIL split_ar%0d got=%h/%0d want=%h/%0d", i, ara_q[a0+i], arl_q[a0+i],
                 ea[i], el[i]);
      end
    end
    checks++;
    if (od_q.size() - b0 != 40) begin
      failures++;
      $display("FAIL split_beats got=%0d want=40", od_q.size() - b0);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (od_q[b0+i] !== pat(64'(i) * 32) || ol_q[b0+i] !== (i == 39)) begin
        failures++;
        $display("FAIL split_beat%0d got=%h last=%b want=%h last=%b", i, od_q[b0+i],
                 ol_q[b0+i], pat(64'(i) * 32), (i == 39));
      end
    end
  endtask

  task automatic test_4k_boundary();
    int a0 = ara_q.size();
    int b0 = od_q.size();
    int d0 = done_n;
    int acc;
    send_cmd(64'h0FC0, 4, acc);
    wait_done(d0, 200, "boundary");
    checks++;
    if (ara_q.size() - a0 != 2 || ara_q[a0] !== 64'h0FC0 || arl_q[a0] !== 8'd1 ||
        ara_q[a0+1] !== 64'h1000 || arl_q[a0+1] !== 8'd1) begin
      failures++;
      $display("FAIL boundary_ars got=%0d ars first=%h/%0d second=%h/%0d want=2 0fc0/1 1000/1",
               ara_q.size() - a0, ara_q[a0], arl_q[a0], ara_q[a0+1], arl_q[a0+1]);
    end
    checks++;
    if (cross_n != 0) begin
      failures++;
      $display("FAIL boundary_cross got=%0d want=0", cross_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od_q[b0+i] !== pat(64'h0FC0 + 64'(i) * 32) || ol_q[b0+i] !== (i == 3)) begin
        failures++;
        $display("FAIL boundary_beat%0d got=%h last=%b want=%h last=%b", i, od_q[b0+i],
                 ol_q[b0+i], pat(64'h0FC0 + 64'(i) * 32), (i == 3));
      end
    end
  endtask

  task automatic test_outstanding();
    int a0 = ara_q.size();
    int b0 = od_q.size();
    int d0 = done_n;
    int m0 = rr_mis;
    int acc;
    int k = 0;
    r_hold = 1'b1;
    send_cmd(64'h2000, 128, acc);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (ara_q.size() - a0 != 4 || bus.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL outst_cap got=%0d ars arvalid=%b want=4 ars arvalid=0",
               ara_q.size() - a0, bus.arvalid);
    end
    r_hold = 1'b0;
    while (done_n == d0 && k < 2000) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      k++;
    end
    out_ready = 1'b1;
    checks++;
    if (done_n == d0) begin
      failures++;
      $display("FAIL outst_done_timeout got=none want=pulse within 2000 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ara_q.size() - a0 != 8) begin
      failures++;
      $display("FAIL outst_ar_total got=%0d want=8", ara_q.size() - a0);
    end
    checks++;
    if (rr_mis != m0) begin
      failures++;
      $display("FAIL outst_rready_mirror got=%0d mismatching cycles want=0", rr_mis - m0);
    end
    checks++;
    if (od_q.size() - b0 != 128) begin
      failures++;
      $display("FAIL outst_beats got=%0d want=128", od_q.size() - b0);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (od_q[b0+i] !== pat(64'h2000 + 64'(i) * 32) || ol_q[b0+i] !== (i == 127)) begin
        failures++;
        $display("FAIL outst_beat%0d got=%h last=%b want=%h last=%b", i, od_q[b0+i],
                 ol_q[b0+i], pat(64'h2000 + 64'(i) * 32), (i == 127));
      end
    end
  endtask

  task automatic test_error();
    int b0 = od_q.size();
    int d0 = done_n;
    int acc;
    err_addr = 64'h3020;
    send_cmd(64'h3000, 4, acc);
    wait_done(d0, 200, "error");
    err_addr = '1;
    checks++;
    if (error !== 1'b1 || err_rise != oc_q[b0+1] + 1) begin
      failures++;
      $display("FAIL error_set got=%b rise@%0d want=1 rise@%0d", error, err_rise,
               oc_q[b0+1] + 1);
    end
    checks++;
    if (od_q.size() - b0 != 4) begin
      failures++;
      $display("FAIL error_beats got=%0d want=4", od_q.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od_q[b0+i] !== pat(64'h3000 + 64'(i) * 32)) begin
        failures++;
        $display("FAIL error_beat%0d got=%h want=%h", i, od_q[b0+i],
                 pat(64'h3000 + 64'(i) * 32));
      end
    end
  endtask

  task automatic test_zero_length();
    int a0 = ara_q.size();
    int b0 = od_q.size();
    int d0 = done_n;
    int acc;
    send_cmd(64'h0, 0, acc);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL zero_error_clear got=%b want=0", error);
    end
    wait_done(d0, 50, "zero");
    checks++;
    if (done_n - d0 != 1 || done_c != acc) begin
      failures++;
      $display("FAIL zero_done got=%0d pulses at %0d want=1 pulse at %0d",
               done_n - d0, done_c, acc);
    end
    checks++;
    if (ara_q.size() != a0 || od_q.size() != b0) begin
      failures++;
      $display("FAIL zero_no_traffic got=%0d ars %0d beats want=0 0",
               ara_q.size() - a0, od_q.size() - b0);
    end
  endtask

  task automatic test_reset_mid_run();
    int k = 0;
    int acc;
    int b0;
    int d0;
    arready_en = 1'b0;
    send_cmd(64'h4000, 64, acc);
    while (bus.arvalid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bus.arvalid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_arvalid_pre got=%b want=1", bus.arvalid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, out_valid, cmd_ready, done, bus.rready} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_async got=%b want=00000",
               {bus.arvalid, out_valid, cmd_ready, done, bus.rready});
    end
    @(negedge clk);
    rst = 1'b0;
    arready_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_cmd_ready got=%b want=1", cmd_ready);
    end
    b0 = od_q.size();
    d0 = done_n;
    send_cmd(64'h5000, 4, acc);
    wait_done(d0, 200, "midrst_fresh");
    checks++;
    if (od_q.size() - b0 != 4) begin
      failures++;
      $display("FAIL midrst_beats got=%0d want=4", od_q.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od_q[b0+i] !== pat(64'h5000 + 64'(i) * 32) || ol_q[b0+i] !== (i == 3)) begin
        failures++;
        $display("FAIL midrst_beat%0d got=%h last=%b want=%h last=%b", i, od_q[b0+i],
                 ol_q[b0+i], pat(64'h5000 + 64'(i) * 32), (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_4k_boundary();
    test_outstanding();
    test_error();
    test_zero_length();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_read_streamer.md
Name: axi_read_streamer

Overview:
AXI4 read master that turns a simple command (start address, beat count) into one or more INCR read bursts on an axi_interface master port. It forwards the returned read data as a valid/ready beat stream with a last marker. It sits directly upstream of any axi_interface slave (memory model or interconnect) and feeds downstream stream consumers. The write channels are tied off.

Parameters:
ID_WIDTH, 1, AXI ID width (must match the connected axi_interface)
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 256, AXI data width in bits; power of two, >= 8
MAX_BURST, 16, maximum beats per burst, 1..256
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts, >= 1
LEN_WIDTH, 32, width of the command beat count

Ports:
ACLK  input  1  clock; all logic on the rising edge
ARST  input  1  asynchronous, active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_addr  input  ADDR_WIDTH  start byte address; the low log2(DATA_WIDTH/8) bits are ignored (treated as 0)
cmd_beats  input  LEN_WIDTH  number of DATA_WIDTH beats to read; 0 is legal
out_valid  output  1  output beat valid
out_ready  input  1  downstream ready
out_data  output  DATA_WIDTH  beat data (= RDATA)
out_last  output  1  final beat of the command
done  output  1  one-cycle pulse when a command completes
error  output  1  sticky; set when any beat returns RRESP != 0
m_axi  interface  -  axi_interface.master, parameterised with ID_WIDTH/ADDR_WIDTH/DATA_WIDTH

Behaviour:
- Reset values (asynchronous): cmd_ready=0, ARVALID=0, RREADY=0, out_valid=0, out_last=0, done=0, error=0. All counters are 0. State is IDLE.
- Tie-offs: AWVALID=0, WVALID=0, BREADY=1. The remaining AW/W outputs are 0.
- Constant AR fields: ARID=0, ARSIZE=log2(DATA_WIDTH/8), ARBURST=2'b01 (INCR). ARLOCK, ARCACHE, ARPROT, ARQOS and ARREGION are 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1.
  - On accept: latch the aligned address; set ar_left=cmd_beats and r_left=cmd_beats; clear error.
  - If cmd_beats==0, go to FIN. Otherwise go to RUN.
- RUN, AR path:
  - ARVALID is registered. It asserts when ar_left>0 and outstanding<MAX_OUTSTANDING. The earliest assertion is the cycle after command accept.
  - Burst length n = min(ar_left, MAX_BURST, beats remaining to the next 4 KiB boundary), where beats to boundary = (4096 - addr[11:0]) / (DATA_WIDTH/8).
  - ARLEN=n-1. ARADDR is the current address.
  - ARADDR, ARLEN and ARVALID stay stable until ARREADY.
  - On the AR handshake: addr += n*DATA_WIDTH/8; ar_left -= n; outstanding++.
- RUN, R path:
  - RREADY=out_ready and out_valid=RVALID. This is a combinational passthrough; out_data=RDATA.
  - On an R handshake: r_left--.
  - On an R handshake with RLAST: outstanding--.
  - If an AR handshake and an R-with-RLAST handshake occur in the same cycle, outstanding is unchanged.
  - out_last=1 on the beat where r_left==1.
  - Any handshake beat with RRESP!=0 sets error. The data is still forwarded.
  - When the handshake takes r_left to 0, go to FIN.
  - RID is ignored.
- FIN: done=1 for exactly one cycle, then go to IDLE.
  - Consequence: cmd_ready is 0 in RUN and FIN.
  - Consequence: a new command is accepted no earlier than one cycle after done.
- Outside RUN: RREADY=0 and out_valid=0.
- Reset mid-operation: all outputs drop immediately (asynchronously). In-flight bursts are abandoned. The bench must reset the slave together with this block.
- Counter widths:
  - ar_left and r_left are LEN_WIDTH bits.
  - outstanding is clog2(MAX_OUTSTANDING+1) bits.
  - The address is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Single burst: addr=0x1000, beats=4, DATA_WIDTH=256, slave always ready -> one AR with ARADDR=0x1000, ARLEN=3, ARSIZE=5, ARBURST=1. Four out beats with out_last on the 4th. done pulses exactly once, one cycle after the 4th beat.
- Split: addr=0x0, beats=40, MAX_BURST=16 -> ARs of (0x000, ARLEN 15), (0x200, 15), (0x400, 7). 40 beats out in order; out_last only on beat 40.
- 4 KiB boundary: addr=0x0FC0, beats=4 -> ARs of (0x0FC0, ARLEN 1) and (0x1000, ARLEN 1). No burst crosses 0x1000.
- Outstanding cap and backpressure:
  - Setup: beats=128, MAX_BURST=16, ARREADY=1, slave withholds R.
  - Required: exactly 4 AR handshakes, then ARVALID=0.
  - Then release R with out_ready toggled 1/0 every cycle: RREADY mirrors out_ready, all 128 beats arrive with no loss or duplication, and the 8 ARs complete.
- Error and zero length:
  - beats=4 with RRESP=2'b10 on beat 2 -> error=1 from the cycle after that beat; all 4 beats are still forwarded.
  - Next command, beats=0 -> error clears on accept, no AR issued, done pulses 1 cycle after accept.
- Reset mid-run: assert ARST while ARVALID=1 -> ARVALID, out_valid, cmd_ready and done go to 0 without waiting for a clock edge. After release, cmd_ready=1 on the first edge and a fresh 4-beat command completes normally.
